// File: rtl/stg0ia.sv
// stg0ia: stage-0 instruction-address generator.
// Owns the fetch PC and drives word addresses into a synchronous 1-cycle
// instruction memory. It presents ow_pc/ow_ia_valid aligned with the memory
// read data so that the stg1 fetch latch can capture them.
// Optional feature: define STG0IA_PERF_EN to add the saturating
// ow_fetch_cnt / ow_redir_cnt performance counters.
module stg0ia #(
    parameter int                 SIZE_ADDR = 32,
    parameter int                 HBIT_ADDR = SIZE_ADDR - 1,
    parameter logic [HBIT_ADDR:0] RESET_PC  = '0
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               iw_stall,
    input  logic               iw_branch,
    input  logic [HBIT_ADDR:0] iw_branch_pc,
    input  logic               iw_mem_ready,
`ifdef STG0IA_PERF_EN
    output logic [15:0]        ow_fetch_cnt,
    output logic [15:0]        ow_redir_cnt,
`endif
    output logic [HBIT_ADDR:0] ow_mem_addr,
    output logic               ow_mem_req,
    output logic [HBIT_ADDR:0] ow_pc,
    output logic               ow_ia_valid
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam logic [HBIT_ADDR:0] ADDR_ONE = {{HBIT_ADDR{1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;
    logic   issue;

    // A request is only "issued" once the memory accepts it.
    assign issue = ow_mem_req && iw_mem_ready;

    // State register.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block evaluation order.
        if (iw_rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a branch always lands in REDIR, otherwise fetch runs.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned,
        // which would infer a latch.
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = iw_branch ? REDIR : RUN;
            RUN:     state_nxt = iw_branch ? REDIR : RUN;
            REDIR:   state_nxt = iw_branch ? REDIR : RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Output logic: request only in RUN, suppressed by stall or a redirect.
    always_comb begin
        ow_mem_req = 1'b0;
        if (state == RUN) begin
            ow_mem_req = !iw_stall && !iw_branch;
        end
    end

    // Fetch PC and the response tag that travels one cycle behind the issue.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ow_mem_addr <= RESET_PC;
            ow_pc       <= '0;
            ow_ia_valid <= 1'b0;
        end else begin
            ow_ia_valid <= issue;
            if (iw_branch) begin
                ow_mem_addr <= iw_branch_pc;
            end else if (issue) begin
                // Word-addressed; wraps naturally at the top of the address space.
                ow_mem_addr <= ow_mem_addr + ADDR_ONE;
                ow_pc       <= ow_mem_addr;
            end
        end
    end

`ifdef STG0IA_PERF_EN
    // Saturating counters of issued fetches and accepted redirects.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ow_fetch_cnt <= 16'd0;
            ow_redir_cnt <= 16'd0;
        end else begin
            if (issue && (ow_fetch_cnt != 16'hFFFF)) begin
                ow_fetch_cnt <= ow_fetch_cnt + 16'd1;
            end
            if (iw_branch && (ow_redir_cnt != 16'hFFFF)) begin
                ow_redir_cnt <= ow_redir_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
